// File: rtl/datapath_seq.sv
// datapath_seq: microsequencer for Datapath that takes each instruction through fetch, decode, execute, write-back and register write
//
// Ports:
//   iClk, iRst        clock and synchronous active-high reset
//   iRun              start/continue; sampled only in IDLE and WRITE
//   iStep             single-step pulse (only with DATAPATH_SEQ_STEP_EN)
//   iMemData/iMemRdy  instruction word and its valid strobe
//   oMemRd            instruction read request (FETCH)
//   oIR               instruction register
//   oBusy/oHalt/oErr  status
//   oPC_* .. oImm32   Datapath control, one-to-one with Datapath inputs
//
// Optional feature macro: DATAPATH_SEQ_STEP_EN (adds iStep, WRITE always returns to IDLE)
module datapath_seq (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iRun,
`ifdef DATAPATH_SEQ_STEP_EN
    input  logic        iStep,
`endif
    input  logic [31:0] iMemData,
    input  logic        iMemRdy,
    output logic        oMemRd,
    output logic [31:0] oIR,
    output logic        oBusy,
    output logic        oHalt,
    output logic        oErr,
    output logic        oPC_nRst,
    output logic        oPC_en,
    output logic        oRF_Write,
    output logic [3:0]  oRF_AddrA,
    output logic [3:0]  oRF_AddrB,
    output logic [3:0]  oRF_AddrC,
    output logic        oRWB_en,
    output logic [3:0]  oALU_Ctrl,
    output logic        oRA_en,
    output logic        oRB_en,
    output logic        oRZH_en,
    output logic        oRZL_en,
    output logic        oMUX_BIS,
    output logic        oMUX_RZHS,
    output logic        oMUX_WBM,
    output logic        oMUX_MAP,
    output logic [31:0] oImm32
);
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_SHL  = 5'd4;
    localparam logic [4:0] OP_SHR  = 5'd5;
    localparam logic [4:0] OP_ROL  = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ADDI = 5'd8;
    localparam logic [4:0] OP_ANDI = 5'd9;
    localparam logic [4:0] OP_ORI  = 5'd10;
    localparam logic [4:0] OP_NEG  = 5'd11;
    localparam logic [4:0] OP_NOT  = 5'd12;
    localparam logic [4:0] OP_NOP  = 5'd13;
    localparam logic [4:0] OP_HALT = 5'd14;

    localparam logic [3:0] CTRL_ALU_ADD = 4'd0;
    localparam logic [3:0] CTRL_ALU_SUB = 4'd1;
    localparam logic [3:0] CTRL_ALU_AND = 4'd2;
    localparam logic [3:0] CTRL_ALU_OR  = 4'd3;
    localparam logic [3:0] CTRL_ALU_SHL = 4'd4;
    localparam logic [3:0] CTRL_ALU_SHR = 4'd5;
    localparam logic [3:0] CTRL_ALU_ROL = 4'd6;
    localparam logic [3:0] CTRL_ALU_ROR = 4'd7;
    localparam logic [3:0] CTRL_ALU_NEG = 4'd8;
    localparam logic [3:0] CTRL_ALU_NOT = 4'd9;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, WRITE, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        pc_nrst_q;
    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    logic        is_r, is_i, is_u, is_alu, accept, start;
    logic [3:0]  alu_ctrl;

    assign op     = ir_q[31:27];
    assign ra     = ir_q[26:23];
    assign rb     = ir_q[22:19];
    assign rc     = ir_q[18:15];
    assign is_r   = op <= OP_ROR;
    assign is_i   = op == OP_ADDI || op == OP_ANDI || op == OP_ORI;
    assign is_u   = op == OP_NEG || op == OP_NOT;
    assign is_alu = is_r || is_i || is_u;
    assign accept = state_q == FETCH && iMemRdy;

`ifdef DATAPATH_SEQ_STEP_EN
    assign start = iRun || iStep;
`else
    assign start = iRun;
`endif

    always_comb begin
        alu_ctrl = CTRL_ALU_ADD;
        case (op)
            OP_ADD, OP_ADDI: alu_ctrl = CTRL_ALU_ADD;
            OP_SUB:          alu_ctrl = CTRL_ALU_SUB;
            OP_AND, OP_ANDI: alu_ctrl = CTRL_ALU_AND;
            OP_OR, OP_ORI:   alu_ctrl = CTRL_ALU_OR;
            OP_SHL:          alu_ctrl = CTRL_ALU_SHL;
            OP_SHR:          alu_ctrl = CTRL_ALU_SHR;
            OP_ROL:          alu_ctrl = CTRL_ALU_ROL;
            OP_ROR:          alu_ctrl = CTRL_ALU_ROR;
            OP_NEG:          alu_ctrl = CTRL_ALU_NEG;
            OP_NOT:          alu_ctrl = CTRL_ALU_NOT;
            default:         alu_ctrl = CTRL_ALU_ADD;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ir_d    = accept ? iMemData : ir_q;
        case (state_q)
            IDLE:   state_d = start ? FETCH : IDLE;
            FETCH:  state_d = iMemRdy ? DECODE : FETCH;
            DECODE: state_d = is_alu ? EXEC : (op == OP_NOP ? FETCH : HALT);
            EXEC:   state_d = WB;
            WB:     state_d = WRITE;
`ifdef DATAPATH_SEQ_STEP_EN
            WRITE:  state_d = IDLE;
`else
            WRITE:  state_d = iRun ? FETCH : IDLE;
`endif
            HALT:   state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            pc_nrst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            pc_nrst_q <= 1'b1;
        end
    end

    // Halt and error share the HALT state; the latched opcode tells them apart.
    assign oMemRd    = state_q == FETCH;
    assign oMUX_MAP  = state_q == FETCH;
    assign oPC_en    = accept;
    assign oIR       = ir_q;
    assign oBusy     = state_q != IDLE && state_q != HALT;
    assign oHalt     = state_q == HALT && op == OP_HALT;
    assign oErr      = state_q == HALT && op != OP_HALT;
    assign oPC_nRst  = pc_nrst_q;
    assign oRF_AddrA = state_q == DECODE ? rb : 4'd0;
    assign oRA_en    = state_q == DECODE;
    assign oRF_AddrB = state_q == DECODE && is_r ? rc : 4'd0;
    assign oRB_en    = state_q == DECODE && is_r;
    assign oALU_Ctrl = state_q == EXEC || state_q == WB ? alu_ctrl : 4'd0;
    assign oRZH_en   = state_q == EXEC;
    assign oRZL_en   = state_q == EXEC;
    assign oMUX_BIS  = state_q == EXEC && is_i;
    assign oMUX_RZHS = 1'b0;
    assign oMUX_WBM  = 1'b0;
    assign oRWB_en   = state_q == WB;
    assign oRF_AddrC = state_q == WRITE ? ra : 4'd0;
    assign oRF_Write = state_q == WRITE;
    assign oImm32    = {{13{ir_q[18]}}, ir_q[18:0]};
endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq: directed checks of datapath_seq against a small behavioural Datapath
module tb_datapath_seq;
    logic        clk = 1'b0;
    logic        iRst, iRun, iMemRdy;
`ifdef DATAPATH_SEQ_STEP_EN
    logic        iStep;
`endif
    logic [31:0] iMemData;
    logic        oMemRd, oBusy, oHalt, oErr, oPC_nRst, oPC_en, oRF_Write;
    logic [31:0] oIR, oImm32;
    logic [3:0]  oRF_AddrA, oRF_AddrB, oRF_AddrC, oALU_Ctrl;
    logic        oRWB_en, oRA_en, oRB_en, oRZH_en, oRZL_en;
    logic        oMUX_BIS, oMUX_RZHS, oMUX_WBM, oMUX_MAP;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    datapath_seq dut (
        .iClk(clk), .iRst(iRst), .iRun(iRun),
`ifdef DATAPATH_SEQ_STEP_EN
        .iStep(iStep),
`endif
        .iMemData(iMemData), .iMemRdy(iMemRdy), .oMemRd(oMemRd), .oIR(oIR),
        .oBusy(oBusy), .oHalt(oHalt), .oErr(oErr), .oPC_nRst(oPC_nRst),
        .oPC_en(oPC_en), .oRF_Write(oRF_Write), .oRF_AddrA(oRF_AddrA),
        .oRF_AddrB(oRF_AddrB), .oRF_AddrC(oRF_AddrC), .oRWB_en(oRWB_en),
        .oALU_Ctrl(oALU_Ctrl), .oRA_en(oRA_en), .oRB_en(oRB_en),
        .oRZH_en(oRZH_en), .oRZL_en(oRZL_en), .oMUX_BIS(oMUX_BIS),
        .oMUX_RZHS(oMUX_RZHS), .oMUX_WBM(oMUX_WBM), .oMUX_MAP(oMUX_MAP),
        .oImm32(oImm32)
    );

    function automatic logic [31:0] alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a << b[4:0];
            4'd5: return a >> b[4:0];
            4'd6: return (a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]}));
            4'd7: return (a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]}));
            4'd8: return -a;
            4'd9: return ~a;
            default: return 32'd0;
        endcase
    endfunction

    logic [31:0] rf [16];
    logic [31:0] reg_a, reg_b, reg_z, reg_wb;
    int          writes = 0;

    always @(posedge clk) begin
        if (iRst) begin
            for (int i = 0; i < 16; i++) rf[i] <= 32'd0;
            rf[5] <= 32'h22;
            rf[7] <= 32'h24;
        end else begin
            if (oRA_en) reg_a <= rf[oRF_AddrA];
            if (oRB_en) reg_b <= rf[oRF_AddrB];
            if (oRZL_en) reg_z <= alu(oALU_Ctrl, reg_a, oMUX_BIS ? oImm32 : reg_b);
            if (oRWB_en) reg_wb <= reg_z;
            if (oRF_Write) begin
                rf[oRF_AddrC] <= reg_wb;
                writes <= writes + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    int cyc, pe, fetch_n;
    logic bis_exec;
    logic [3:0] alu_exec, addr_c;

    // Starts one instruction from IDLE, withholding iMemRdy for wait_cyc FETCH cycles.
    task automatic run_one(input logic [31:0] instr, input int wait_cyc);
        cyc = 0; pe = 0; fetch_n = 0; bis_exec = 0; alu_exec = 0; addr_c = 0;
        iMemData = instr;
        iMemRdy = 1'b0;
        iRun = 1'b1;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            iRun = 1'b0;
            if (oMemRd) begin
                fetch_n++;
                iMemRdy = fetch_n > wait_cyc;
            end
            #1;
            if (oPC_en) pe++;
            if (oRZL_en) begin
                bis_exec = oMUX_BIS;
                alu_exec = oALU_Ctrl;
            end
            if (oRF_Write) begin
                addr_c = oRF_AddrC;
                break;
            end
            if (oHalt || oErr) break;
        end
        @(negedge clk);
    endtask

    initial begin
        iRst = 1'b1; iRun = 1'b0; iMemRdy = 1'b0; iMemData = 32'd0;
`ifdef DATAPATH_SEQ_STEP_EN
        iStep = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_pc_nrst", {31'd0, oPC_nRst}, 32'd0);
        chk("rst_busy", {31'd0, oBusy}, 32'd0);
        chk("rst_ir", oIR, 32'd0);
        iRst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_pc_nrst", {31'd0, oPC_nRst}, 32'd1);
        chk("idle_busy", {31'd0, oBusy}, 32'd0);
        chk("idle_memrd", {31'd0, oMemRd}, 32'd0);
        chk("idle_enables", {oPC_en, oRF_Write, oRA_en, oRB_en, oRZL_en, oRWB_en}, 32'd0);

        // add R3,R5,R7
        run_one({5'd0, 4'd3, 4'd5, 4'd7, 15'd0}, 0);
        chk("add_cycles", cyc, 5);
        chk("add_addrc", {28'd0, addr_c}, 32'd3);
        chk("add_pc_en", pe, 1);
        chk("add_r3", rf[3], 32'h46);
        chk("add_idle", {31'd0, oBusy}, 32'd0);

        // neg R4,R5
        run_one({5'd11, 4'd4, 4'd5, 19'd0}, 0);
        chk("neg_alu", {28'd0, alu_exec}, 32'd8);
        chk("neg_r4", rf[4], 32'hFFFFFFDE);

        // addi R6,R5,-2
        run_one({5'd8, 4'd6, 4'd5, 19'h7FFFE}, 0);
        chk("addi_imm", oImm32, 32'hFFFFFFFE);
        chk("addi_bis", {31'd0, bis_exec}, 32'd1);
        chk("addi_r6", rf[6], 32'h20);

        // sub R8,R7,R5 with three wait cycles
        run_one({5'd1, 4'd8, 4'd7, 4'd5, 15'd0}, 3);
        chk("wait_cycles", cyc, 8);
        chk("wait_fetch", fetch_n, 4);
        chk("wait_pc_en", pe, 1);
        chk("wait_r8", rf[8], 32'h2);

        // nop then halt
        iMemData = {5'd13, 27'd0}; iMemRdy = 1'b1; iRun = 1'b1;
        @(negedge clk); iRun = 1'b0;
        chk("nop_fetch", {31'd0, oPC_en}, 32'd1);
        @(negedge clk);
        chk("nop_decode", {oRA_en, oMemRd}, 32'd2);
        iMemData = {5'd14, 27'd0};
        @(negedge clk);
        chk("nop_refetch", {31'd0, oMemRd}, 32'd1);
        repeat (2) @(negedge clk);
        chk("halt_flags", {oHalt, oErr, oBusy}, 32'b100);

        // illegal opcode
        iRst = 1'b1; @(negedge clk); iRst = 1'b0; @(negedge clk);
        writes = writes;
        begin
            int w0;
            w0 = writes;
            run_one({5'd31, 27'd0}, 0);
            chk("ill_flags", {oHalt, oErr}, 32'b01);
            iRun = 1'b1;
            repeat (10) @(negedge clk);
            chk("ill_sticky", {oHalt, oErr, oBusy, oRF_Write}, 32'b0100);
            chk("ill_nowrite", writes - w0, 0);
        end
        iRun = 1'b0; iRst = 1'b1; @(negedge clk); iRst = 1'b0; @(negedge clk);
        chk("ill_rst", {oErr, oBusy, oPC_nRst}, 32'b001);

        // reset during EXEC of sub R9,R7,R5
        begin
            int w0, n;
            w0 = writes;
            n = 0;
            iMemData = {5'd1, 4'd9, 4'd7, 4'd5, 15'd0}; iMemRdy = 1'b1; iRun = 1'b1;
            while (!oRZL_en && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("exec_reached", {31'd0, oRZL_en}, 32'd1);
            iRst = 1'b1; @(negedge clk); iRst = 1'b0; iRun = 1'b0;
            repeat (4) @(negedge clk);
            chk("exec_rst_nowrite", writes - w0, 0);
            chk("exec_rst_idle", {oBusy, oMemRd}, 32'd0);
        end

`ifdef DATAPATH_SEQ_STEP_EN
        iMemData = {5'd0, 4'd10, 4'd5, 4'd7, 15'd0}; iMemRdy = 1'b1;
        iStep = 1'b1; @(negedge clk); iStep = 1'b0;
        repeat (6) @(negedge clk);
        chk("step_r10", rf[10], 32'h46);
        chk("step_idle", {oBusy, oMemRd}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
